xrs_wbctl: RTL
==============

# xrs_wbctl

Write-back controller and load scoreboard for the `xrs` register file. It merges two write-back sources onto the single `xrs` write port: the ALU, which can be back-pressured, and the load unit, which cannot. It also tracks registers with loads in flight so that issue logic can stall on RAW and WAW hazards. It sits between the execute/memory stages and `xrs`, and drives `rd_i`, `rdat_i` and `rwe_i` directly.

## Interface
- `MAXLD`, default 2: maximum number of outstanding loads (1..7).
- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `iss_valid_i` in 1: a load is being issued this cycle.
- `iss_rd_i` in 5: destination register of the issued load.
- `iss_ready_o` out 1: a load may be issued (`count < MAXLD`).
- `ra_i`, `rb_i` in 5 each: source registers of the instruction in decode.
- `hazard_o` out 1: `busy[ra_i] | busy[rb_i]`. Combinational.
- `ld_valid_i` in 1: load data is returning. Cannot be stalled.
- `ld_rd_i` in 5: destination register of the returning load.
- `ld_rwe_i` in 3: width and extension code for the load (`XRS_RWE_*`).
- `ld_dat_i` in 64: returned load data.
- `alu_valid_i` in 1: ALU write-back request.
- `alu_rd_i` in 5: ALU destination register.
- `alu_dat_i` in 64: ALU result.
- `alu_ready_o` out 1: ALU request is accepted this cycle. Combinational.
- `xrs_rd_o` out 5: to `xrs.rd_i`. Registered.
- `xrs_rdat_o` out 64: to `xrs.rdat_i`. Registered.
- `xrs_rwe_o` out 3: to `xrs.rwe_i`. Registered.
- `busy_o` out 32: scoreboard bit vector.
- `count_o` out 3: number of outstanding loads.
- `err_o` out 1: sticky protocol-error flag.

## Operation
- **Scoreboard.** One `busy` bit per register. `busy[0]` is hard-wired to 0.
  - Accepted issue (`iss_valid_i & iss_ready_o`) sets `busy[iss_rd_i]` and increments `count`.
  - `ld_valid_i` clears `busy[ld_rd_i]` and decrements `count`.
  - Issue while `iss_ready_o` is 0 is ignored and sets `err_o`.
- **Simultaneous events.**
  - Issue and completion in the same cycle leave `count` unchanged.
  - If both target the same register, the set wins and the bit stays 1.
- **Load write-back.** Always granted in the cycle it arrives:
  - `xrs_rd_o <= ld_rd_i`, `xrs_rdat_o <= ld_dat_i`, `xrs_rwe_o <= ld_rwe_i`.
  - If `ld_rd_i == 0`, `xrs_rwe_o <= XRS_RWE_NO`.
- **ALU write-back.**
  - `alu_ready_o = ~ld_valid_i & ~busy[alu_rd_i]`. Loads win the port, and a WAW against a pending load stalls the ALU.
  - When accepted: `xrs_rwe_o <= XRS_RWE_S64`, or `XRS_RWE_NO` if `alu_rd_i == 0`.
- **Idle cycles.** With no grant, `xrs_rwe_o <= XRS_RWE_NO`. `xrs_rd_o` and `xrs_rdat_o` hold their values.
- **Protocol errors.** `ld_valid_i` while `count == 0` sets `err_o`, and `count` saturates at 0. `err_o` clears only on reset.
- **Extension.** Width arithmetic is done in `xrs`. This block only passes the RWE code through.

## Timing
- **Reset** (asynchronous, immediate) sets:
  - `busy = 0`, `count = 0`, `err_o = 0`;
  - `xrs_rd_o = 0`, `xrs_rdat_o = 0`, `xrs_rwe_o = XRS_RWE_NO`.
  - Loads in flight at reset are discarded.
- **Write latency.** A grant at edge N puts the request on the `xrs_*_o` outputs after edge N. `xrs` commits it at edge N+1.
- **Busy clear.** The busy bit clears at edge N, together with the grant register. Decode therefore sees `hazard_o = 0` one cycle before `xrs` commits the write. Decode forwarding from `xrs_*_o` covers that cycle; this block adds no bypass.
- **Combinational outputs.** `iss_ready_o`, `hazard_o` and `alu_ready_o` depend on registered state and current inputs only. There is no combinational path from `xrs_*_o`.
- **Throughput.** One write per cycle. An ALU request stalled by `ld_valid_i` is accepted in the first cycle without a load.

## Structure
- The `XRS_RWE_*` codes stay in `xrs.vh`; this block includes that file.
- Add `xrs_wbctl.vh` holding `XRS_WBCTL_MAXLD_DEFAULT`.
- One sub-module, `xrs_sb`: the 32-bit busy vector plus the counter and `err_o`. Ports: set, clear, index inputs; `busy_o`, `count_o`.
- The top level holds the grant mux and the output registers.

## Test plan
- **Reset.** Assert `reset_i` mid-cycle with `busy[5]=1` and `count=1` -> all of busy, count and `err_o` are 0 immediately, `xrs_rwe_o = XRS_RWE_NO`, and `alu_ready_o = 1`.
- **Load RAW.** Issue load `rd=3`, hold `ra_i=3` -> `hazard_o = 1`. Then `ld_valid_i` with `rd=3`, `rwe=XRS_RWE_S8`, `dat=64'h...80` -> after the edge: `hazard_o = 0`, `xrs_rd_o = 3`, `xrs_rwe_o = XRS_RWE_S8`. On the next cycle `xrs` reads `64'hFFFFFFFFFFFFFF80`.
- **Port conflict.** ALU `rd=1`, `dat=64'h1122334455667788` in the same cycle as load `rd=2` -> `alu_ready_o = 0`, load written first; ALU written the following cycle. `xrs` then reads r1 = `64'h1122334455667788` and r2 = load data.
- **WAW stall.** Pending load to r4 plus ALU request to r4 -> `alu_ready_o = 0` until the load returns. Final r4 = ALU value.
- **Counter limits.** With `MAXLD=2`: two issues -> `iss_ready_o = 0`. A third issue -> `err_o = 1` and `count` stays 2. Simultaneous issue and completion -> `count` unchanged.
- **x0 handling.** Load and ALU to `rd=0` -> `xrs_rwe_o = XRS_RWE_NO`, `busy[0] = 0`, and `xrs` reads r0 = 0.

Source files
------------

// File: rtl/xrs_wbctl_pkg.sv
// ---------------------------------------------------------------------------
// xrs_wbctl_pkg : shared RWE codes, default sizing and helpers for xrs_wbctl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package xrs_wbctl_pkg;

    localparam int XRS_WBCTL_MAXLD_DEFAULT = 2;

    typedef enum logic [2:0] {
        XRS_RWE_NO  = 3'd0,
        XRS_RWE_S8  = 3'd1,
        XRS_RWE_S16 = 3'd2,
        XRS_RWE_S32 = 3'd3,
        XRS_RWE_S64 = 3'd4,
        XRS_RWE_U8  = 3'd5,
        XRS_RWE_U16 = 3'd6,
        XRS_RWE_U32 = 3'd7
    } xrs_rwe_e;

    // Writes aimed at x0 are turned into no-ops before they reach xrs.
    function automatic logic [2:0] wb_rwe(input logic [4:0] rd, input logic [2:0] rwe);
        return (rd == 5'd0) ? XRS_RWE_NO : rwe;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xrs_sb.sv
// ---------------------------------------------------------------------------
// xrs_sb : load scoreboard - per-register busy bits, in-flight count, error
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xrs_sb
    import xrs_wbctl_pkg::*;
#(
    parameter int MAXLD = XRS_WBCTL_MAXLD_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        set_i,
    input  logic [4:0]  set_idx_i,
    input  logic        clr_i,
    input  logic [4:0]  clr_idx_i,
    output logic        ready_o,
    output logic [31:0] busy_o,
    output logic [2:0]  count_o,
    output logic        err_o
);

    logic [31:0] busy_nxt;
    logic [2:0]  count_nxt;
    logic        err_nxt;
    logic        inc;
    logic        dec;

    always_comb begin
        ready_o   = (count_o < 3'(MAXLD));
        inc       = set_i & ready_o;
        dec       = clr_i & (count_o != 3'd0);
        count_nxt = count_o + {2'b00, inc} - {2'b00, dec};
        err_nxt   = err_o | (set_i & ~ready_o) | (clr_i & (count_o == 3'd0));
        busy_nxt  = busy_o;
        // Clear first so a same-register issue in the same cycle wins.
        if (clr_i)
            busy_nxt[clr_idx_i] = 1'b0;
        if (inc)
            busy_nxt[set_idx_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_o  <= '0;
            count_o <= '0;
            err_o   <= 1'b0;
        end else begin
            busy_o  <= busy_nxt;
            count_o <= count_nxt;
            err_o   <= err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/xrs_wbctl.sv
// ---------------------------------------------------------------------------
// xrs_wbctl : merges load and ALU write-back onto the single xrs write port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xrs_wbctl
    import xrs_wbctl_pkg::*;
#(
    parameter int MAXLD = XRS_WBCTL_MAXLD_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        iss_valid_i,
    input  logic [4:0]  iss_rd_i,
    output logic        iss_ready_o,
    input  logic [4:0]  ra_i,
    input  logic [4:0]  rb_i,
    output logic        hazard_o,
    input  logic        ld_valid_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [2:0]  ld_rwe_i,
    input  logic [63:0] ld_dat_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [63:0] alu_dat_i,
    output logic        alu_ready_o,
    output logic [4:0]  xrs_rd_o,
    output logic [63:0] xrs_rdat_o,
    output logic [2:0]  xrs_rwe_o,
    output logic [31:0] busy_o,
    output logic [2:0]  count_o,
    output logic        err_o
);

    xrs_sb #(
        .MAXLD (MAXLD)
    ) u_sb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_i     (iss_valid_i),
        .set_idx_i (iss_rd_i),
        .clr_i     (ld_valid_i),
        .clr_idx_i (ld_rd_i),
        .ready_o   (iss_ready_o),
        .busy_o    (busy_o),
        .count_o   (count_o),
        .err_o     (err_o)
    );

    assign hazard_o    = busy_o[ra_i] | busy_o[rb_i];
    // Loads cannot stall, so they own the port; ALU also waits out a WAW.
    assign alu_ready_o = ~ld_valid_i & ~busy_o[alu_rd_i];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            xrs_rd_o   <= 5'd0;
            xrs_rdat_o <= 64'd0;
            xrs_rwe_o  <= XRS_RWE_NO;
        end else if (ld_valid_i) begin
            xrs_rd_o   <= ld_rd_i;
            xrs_rdat_o <= ld_dat_i;
            xrs_rwe_o  <= wb_rwe(ld_rd_i, ld_rwe_i);
        end else if (alu_valid_i & alu_ready_o) begin
            xrs_rd_o   <= alu_rd_i;
            xrs_rdat_o <= alu_dat_i;
            xrs_rwe_o  <= wb_rwe(alu_rd_i, XRS_RWE_S64);
        end else begin
            xrs_rwe_o  <= XRS_RWE_NO;
        end
    end

endmodule

`default_nettype wire
